mem_port_sched: RTL and testbench

- Scheduler that shares the single memory-system port between three requesters: D-cache line miss (with optional dirty eviction), D-cache uncached IO access, and I-cache line miss.
- Sits between the dcache/icache miss interfaces and the memory bus controller.
- Sequences eviction write-back before line fill, returns fill data and one-cycle acks to requesters, and applies bounded-starvation priority.

---
 rtl/mem_port_sched.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_port_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sched.sv
// Shares one memory-bus port between D-cache miss/evict, uncached IO and I-cache miss.
// Optional bus-ack timeout is compiled in when MEM_PORT_TIMEOUT_EN is defined.
module mem_port_sched #(
    parameter int STARVE_LIMIT = 2
`ifdef MEM_PORT_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dc_miss,
    input  logic [31:0]  dc_miss_addr,
    input  logic         dc_evict,
    input  logic [31:0]  dc_evict_addr,
    input  logic [127:0] dc_evict_data,
    output logic [127:0] dc_data_fill,
    output logic         dc_miss_ack,
    input  logic         io_access,
    input  logic         io_rw,
    input  logic [31:0]  io_addr,
    input  logic [31:0]  io_wr_data,
    output logic [31:0]  io_rd_data,
    output logic         io_ack,
    input  logic         ic_miss,
    input  logic [31:0]  ic_miss_addr,
    output logic [127:0] ic_data_fill,
    output logic         ic_miss_ack,
    output logic         bus_req,
    output logic         bus_rw,
    output logic         bus_io,
    output logic [31:0]  bus_addr,
    output logic [127:0] bus_wdata,
    input  logic [127:0] bus_rdata,
    input  logic         bus_ack,
    output logic         bus_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, EVICT, FILL, IO, IFILL, RECOVER} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [31:0]    fill_addr_q, fill_addr_d;
    logic           bus_req_q, bus_req_d, bus_rw_q, bus_rw_d, bus_io_q, bus_io_d;
    logic [31:0]    bus_addr_q, bus_addr_d;
    logic [127:0]   bus_wdata_q, bus_wdata_d;
    logic [127:0]   dc_fill_q, dc_fill_d, ic_fill_q, ic_fill_d;
    logic [31:0]    io_rd_q, io_rd_d;
    logic           dc_ack_q, dc_ack_d, io_ack_q, io_ack_d, ic_ack_q, ic_ack_d;
    logic           ic_force, grant_ic, grant_io, grant_dc;
`ifdef MEM_PORT_TIMEOUT_EN
    logic [7:0]     tmo_q, tmo_d;
    logic           tmo_hit;
    logic           bus_err_q, bus_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            fill_addr_q <= '0;
            bus_req_q   <= 1'b0;
            bus_rw_q    <= 1'b0;
            bus_io_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            dc_fill_q   <= '0;
            ic_fill_q   <= '0;
            io_rd_q     <= '0;
            dc_ack_q    <= 1'b0;
            io_ack_q    <= 1'b0;
            ic_ack_q    <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
            tmo_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            fill_addr_q <= fill_addr_d;
            bus_req_q   <= bus_req_d;
            bus_rw_q    <= bus_rw_d;
            bus_io_q    <= bus_io_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            dc_fill_q   <= dc_fill_d;
            ic_fill_q   <= ic_fill_d;
            io_rd_q     <= io_rd_d;
            dc_ack_q    <= dc_ack_d;
            io_ack_q    <= io_ack_d;
            ic_ack_q    <= ic_ack_d;
`ifdef MEM_PORT_TIMEOUT_EN
            tmo_q       <= tmo_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        fill_addr_d = fill_addr_q;
        bus_req_d   = bus_req_q;
        bus_rw_d    = bus_rw_q;
        bus_io_d    = bus_io_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        dc_fill_d   = dc_fill_q;
        ic_fill_d   = ic_fill_q;
        io_rd_d     = io_rd_q;
        dc_ack_d    = 1'b0;
        io_ack_d    = 1'b0;
        ic_ack_d    = 1'b0;

        // A starved I-cache miss overrides the fixed io > dc > ic order.
        ic_force = ic_miss && (starve_q == SW'(STARVE_LIMIT));
        grant_ic = (state_q == IDLE) && ic_miss && (ic_force || (!io_access && !dc_miss));
        grant_io = (state_q == IDLE) && io_access && !ic_force;
        grant_dc = (state_q == IDLE) && dc_miss && !io_access && !ic_force;

        if (!ic_miss || grant_ic) begin
            starve_d = '0;
        end else if ((grant_io || grant_dc) && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end

        case (state_q)
            IDLE: begin
                if (grant_ic) begin
                    state_d     = IFILL;
                    bus_req_d   = 1'b1;
                    bus_rw_d    = 1'b0;
                    bus_io_d    = 1'b0;
                    bus_addr_d  = ic_miss_addr;
                    bus_wdata_d = '0;
                end else if (grant_io) begin
                    state_d     = IO;
                    bus_req_d   = 1'b1;
                    bus_rw_d    = io_rw;
                    bus_io_d    = 1'b1;
                    bus_addr_d  = io_addr;
                    bus_wdata_d = {96'd0, io_wr_data};
                end else if (grant_dc) begin
                    bus_req_d   = 1'b1;
                    bus_io_d    = 1'b0;
                    fill_addr_d = dc_miss_addr;
                    if (dc_evict) begin
                        state_d     = EVICT;
                        bus_rw_d    = 1'b1;
                        bus_addr_d  = dc_evict_addr;
                        bus_wdata_d = dc_evict_data;
                    end else begin
                        state_d     = FILL;
                        bus_rw_d    = 1'b0;
                        bus_addr_d  = dc_miss_addr;
                        bus_wdata_d = '0;
                    end
                end
            end
            EVICT: begin
                // bus_req drops for one cycle between write-back and fill.
                if (bus_ack) begin
                    state_d     = FILL;
                    bus_req_d   = 1'b0;
                    bus_rw_d    = 1'b0;
                    bus_addr_d  = fill_addr_q;
                    bus_wdata_d = '0;
                end
            end
            FILL: begin
                if (!bus_req_q) begin
                    bus_req_d = 1'b1;
                end else if (bus_ack) begin
                    state_d   = RECOVER;
                    bus_req_d = 1'b0;
                    dc_fill_d = bus_rdata;
                    dc_ack_d  = 1'b1;
                end
            end
            IO: begin
                if (bus_ack) begin
                    state_d   = RECOVER;
                    bus_req_d = 1'b0;
                    bus_rw_d  = 1'b0;
                    bus_io_d  = 1'b0;
                    io_rd_d   = bus_rw_q ? 32'd0 : bus_rdata[31:0];
                    io_ack_d  = 1'b1;
                end
            end
            IFILL: begin
                if (bus_ack) begin
                    state_d   = RECOVER;
                    bus_req_d = 1'b0;
                    ic_fill_d = bus_rdata;
                    ic_ack_d  = 1'b1;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef MEM_PORT_TIMEOUT_EN
        bus_err_d = 1'b0;
        tmo_d     = bus_req_q ? tmo_q + 8'd1 : 8'd0;
        tmo_hit   = bus_req_q && !bus_ack && (tmo_q == 8'(TIMEOUT_CYC - 1));
        if (tmo_hit) begin
            state_d   = RECOVER;
            bus_req_d = 1'b0;
            bus_rw_d  = 1'b0;
            bus_io_d  = 1'b0;
            bus_err_d = 1'b1;
            case (state_q)
                EVICT, FILL: begin dc_fill_d = '0; dc_ack_d = 1'b1; end
                IO:          begin io_rd_d   = '0; io_ack_d = 1'b1; end
                IFILL:       begin ic_fill_d = '0; ic_ack_d = 1'b1; end
                default: ;
            endcase
        end
`endif
    end

    assign dc_data_fill = dc_fill_q;
    assign dc_miss_ack  = dc_ack_q;
    assign io_rd_data   = io_rd_q;
    assign io_ack       = io_ack_q;
    assign ic_data_fill = ic_fill_q;
    assign ic_miss_ack  = ic_ack_q;
    assign bus_req      = bus_req_q;
    assign bus_rw       = bus_rw_q;
    assign bus_io       = bus_io_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
`ifdef MEM_PORT_TIMEOUT_EN
    assign bus_err      = bus_err_q;
`else
    assign bus_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched: vector table of single transactions plus
// hand-written sequences for arbitration order, starvation, reset and recovery.
module tb_mem_port_sched;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         dc_miss, dc_evict, dc_miss_ack;
    logic [31:0]  dc_miss_addr, dc_evict_addr;
    logic [127:0] dc_evict_data, dc_data_fill;
    logic         io_access, io_rw, io_ack;
    logic [31:0]  io_addr, io_wr_data, io_rd_data;
    logic         ic_miss, ic_miss_ack;
    logic [31:0]  ic_miss_addr;
    logic [127:0] ic_data_fill;
    logic         bus_req, bus_rw, bus_io, bus_ack, bus_err;
    logic [31:0]  bus_addr;
    logic [127:0] bus_wdata, bus_rdata;

    mem_port_sched dut (
        .clk(clk), .rst_n(rst_n),
        .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr), .dc_evict(dc_evict),
        .dc_evict_addr(dc_evict_addr), .dc_evict_data(dc_evict_data),
        .dc_data_fill(dc_data_fill), .dc_miss_ack(dc_miss_ack),
        .io_access(io_access), .io_rw(io_rw), .io_addr(io_addr), .io_wr_data(io_wr_data),
        .io_rd_data(io_rd_data), .io_ack(io_ack),
        .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr), .ic_data_fill(ic_data_fill),
        .ic_miss_ack(ic_miss_ack),
        .bus_req(bus_req), .bus_rw(bus_rw), .bus_io(bus_io), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] all_outs();
        return 512'({dc_data_fill, dc_miss_ack, io_rd_data, io_ack, ic_data_fill, ic_miss_ack,
                     bus_req, bus_rw, bus_io, bus_addr, bus_wdata, bus_err});
    endfunction

    // bus controller model: logs each transaction, acks after ack_dly cycles
    int           ack_dly = 1;
    logic [127:0] resp_q[$];
    logic [161:0] obs_q[$];
    int           start_q[$];
    int           ack_cyc_q[$];
    int           inj_req = 0;
    int           inj_done = 0;

    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus_req) begin
                obs_q.push_back({bus_rw, bus_io, bus_addr, bus_wdata});
                start_q.push_back(cyc);
                for (int k = 0; k < ack_dly && rst_n; k++) @(negedge clk);
                if (rst_n) begin
                    bus_ack   = 1'b1;
                    bus_rdata = (resp_q.size() > 0) ? resp_q.pop_front() : 128'hDEAD;
                    ack_cyc_q.push_back(cyc);
                    @(negedge clk);
                    bus_ack = 1'b0;
                end
            end else if (inj_done != inj_req) begin
                bus_ack   = 1'b1;
                bus_rdata = {4{32'hBAD0_BAD0}};
                @(negedge clk);
                bus_ack = 1'b0;
                inj_done++;
            end
        end
    end

    // driver tasks
    task automatic clear_reqs();
        dc_miss = 0; dc_evict = 0; dc_miss_addr = '0; dc_evict_addr = '0; dc_evict_data = '0;
        io_access = 0; io_rw = 0; io_addr = '0; io_wr_data = '0;
        ic_miss = 0; ic_miss_addr = '0;
    endtask

    task automatic wait_ack(input int which, input int budget, output int lat, output logic [127:0] data);
        logic [2:0] acks;
        bit got;
        got  = 0;
        lat  = -1;
        data = '0;
        for (int n = 1; n <= budget && !got; n++) begin
            @(negedge clk);
            acks = {ic_miss_ack, io_ack, dc_miss_ack};
            if (acks != 3'b000) begin
                check("ack_select", 512'(acks), 512'(3'b001 << which));
                got  = 1;
                lat  = n;
                data = (which == 0) ? dc_data_fill : (which == 1) ? {96'd0, io_rd_data} : ic_data_fill;
                if (which == 0) dc_miss = 0;
                else if (which == 1) io_access = 0;
                else ic_miss = 0;
            end
        end
        if (!got) begin
            check("ack_timeout", 512'(0), 512'(1));
        end else begin
            @(negedge clk);
            check("ack_one_cycle", 512'({ic_miss_ack, io_ack, dc_miss_ack}), 512'(0));
        end
    endtask

    logic [131:0] got_q[$];

    task automatic collect(input int n, input bit hold_dc, input int budget);
        int seen;
        seen = 0;
        for (int t = 0; t < budget && seen < n; t++) begin
            @(negedge clk);
            if (dc_miss_ack) begin
                got_q.push_back({4'd0, dc_data_fill});
                seen++;
                if (!hold_dc || seen >= n) dc_miss = 0;
            end
            if (io_ack) begin
                got_q.push_back({4'd1, 96'd0, io_rd_data});
                seen++;
                io_access = 0;
            end
            if (ic_miss_ack) begin
                got_q.push_back({4'd2, ic_data_fill});
                seen++;
                ic_miss = 0;
            end
        end
        check("collect_count", 512'(seen), 512'(n));
    endtask

    task automatic quiet(input int n, output int acks_seen);
        acks_seen = 0;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            if (dc_miss_ack || io_ack || ic_miss_ack) acks_seen++;
        end
    endtask

    // vector table: kind 0=dc read, 1=dc evict+fill, 2=io read, 3=io write, 4=ic fill
    typedef struct {
        int           kind;
        logic [31:0]  addr;
        logic [31:0]  vaddr;
        logic [127:0] vdata;
        logic [31:0]  wdata;
        logic [127:0] rd0;
        logic [127:0] rd1;
        int           dly;
        logic [127:0] exp_out;
        int           exp_lat;
    } vec_t;

    function automatic vec_t mk(input int kind, input logic [31:0] addr, input logic [31:0] vaddr,
                                input logic [127:0] vdata, input logic [31:0] wdata,
                                input logic [127:0] rd0, input logic [127:0] rd1, input int dly,
                                input logic [127:0] exp_out, input int exp_lat);
        vec_t v;
        v.kind = kind; v.addr = addr; v.vaddr = vaddr; v.vdata = vdata; v.wdata = wdata;
        v.rd0 = rd0; v.rd1 = rd1; v.dly = dly; v.exp_out = exp_out; v.exp_lat = exp_lat;
        return v;
    endfunction

    // read transactions carry no meaningful write data
    function automatic logic [161:0] mask_rd(input logic [161:0] e);
        return e[161] ? e : {e[161:128], 128'd0};
    endfunction

    vec_t vecs[5];

    initial begin
        vec_t         v;
        int           lat, which, acks_n;
        bit           got;
        logic [127:0] data;
        logic [161:0] exp0, exp1;
        logic [127:0] last_dc;

        rst_n = 0;
        clear_reqs();
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), '0);
        rst_n = 1;
        @(negedge clk);
        check("idle_after_reset", all_outs(), '0);

        vecs[0] = mk(0, 32'h0000_1230, 32'h0, '0, 32'h0, {16{8'hA5}}, '0, 3, {16{8'hA5}}, 5);
        vecs[1] = mk(1, 32'h0000_2340, 32'h0000_4560, {16{8'h11}}, 32'h0, '0,
                     128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1,
                     128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 6);
        vecs[2] = mk(2, 32'h0000_F004, 32'h0, '0, 32'h0,
                     128'h1111_2222_3333_4444_CAFE_BABE_DEAD_BEEF, '0, 1, 128'hDEAD_BEEF, 3);
        vecs[3] = mk(3, 32'h0000_F008, 32'h0, '0, 32'h1234_5678, {128{1'b1}}, '0, 1, '0, 3);
        vecs[4] = mk(4, 32'h0000_8880, 32'h0, '0, 32'h0, {16{8'h5A}}, '0, 1, {16{8'h5A}}, 3);

        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            obs_q.delete(); start_q.delete(); ack_cyc_q.delete();
            ack_dly = v.dly;
            resp_q.push_back(v.rd0);
            if (v.kind == 1) resp_q.push_back(v.rd1);
            case (v.kind)
                0, 1: begin
                    dc_miss = 1; dc_miss_addr = v.addr; dc_evict = (v.kind == 1);
                    dc_evict_addr = v.vaddr; dc_evict_data = v.vdata;
                end
                2, 3: begin
                    io_access = 1; io_rw = (v.kind == 3); io_addr = v.addr; io_wr_data = v.wdata;
                end
                default: begin
                    ic_miss = 1; ic_miss_addr = v.addr;
                end
            endcase
            which = (v.kind <= 1) ? 0 : (v.kind <= 3) ? 1 : 2;
            if (v.kind == 1)
                exp0 = {1'b1, 1'b0, v.vaddr, v.vdata};
            else if (v.kind == 2 || v.kind == 3)
                exp0 = {v.kind == 3, 1'b1, v.addr, 96'd0, v.wdata};
            else
                exp0 = {2'b00, v.addr, 128'd0};
            exp1 = {2'b00, v.addr, 128'd0};

            wait_ack(which, 60, lat, data);
            check($sformatf("v%0d_latency", i), 512'(lat), 512'(v.exp_lat));
            check($sformatf("v%0d_data", i), 512'(data), 512'(v.exp_out));
            check($sformatf("v%0d_bus_count", i), 512'(obs_q.size()), 512'((v.kind == 1) ? 2 : 1));
            if (obs_q.size() >= 1)
                check($sformatf("v%0d_bus0", i), 512'(mask_rd(obs_q[0])), 512'(mask_rd(exp0)));
            if (v.kind == 1 && obs_q.size() >= 2 && ack_cyc_q.size() >= 1) begin
                check($sformatf("v%0d_bus1", i), 512'(mask_rd(obs_q[1])), 512'(mask_rd(exp1)));
                check($sformatf("v%0d_req_gap", i), 512'(start_q[1] - ack_cyc_q[0]), 512'(2));
            end
            dc_evict = 0;
        end
        check("dc_fill_held", 512'(dc_data_fill), 512'(vecs[1].rd1));
        last_dc = vecs[1].rd1;

        // bus_ack while idle must be ignored
        obs_q.delete();
        inj_req++;
        quiet(4, acks_n);
        check("idle_ack_no_pulse", 512'(acks_n), 512'(0));
        check("idle_ack_fill_held", 512'(dc_data_fill), 512'(last_dc));

        // simultaneous io, dc, ic: service order io > dc > ic
        got_q.delete();
        ack_dly = 1;
        resp_q.push_back(128'h0000_0000_0000_0000_0000_0000_7777_8888);
        resp_q.push_back({4{32'h3C3C_3C3C}});
        resp_q.push_back({4{32'hC3C3_C3C3}});
        io_access = 1; io_rw = 0; io_addr = 32'h0000_F004; io_wr_data = '0;
        dc_miss = 1; dc_miss_addr = 32'h0000_3000; dc_evict = 0;
        ic_miss = 1; ic_miss_addr = 32'h0000_7000;
        collect(3, 0, 80);
        if (got_q.size() == 3) begin
            check("order_0_io", 512'(got_q[0]), 512'({4'd1, 96'd0, 32'h7777_8888}));
            check("order_1_dc", 512'(got_q[1]), 512'({4'd0, {4{32'h3C3C_3C3C}}}));
            check("order_2_ic", 512'(got_q[2]), 512'({4'd2, {4{32'hC3C3_C3C3}}}));
        end
        @(negedge clk);

        // dc held continuously with ic pending: two dc grants, then ic forced
        got_q.delete();
        resp_q.push_back({4{32'h0000_00D1}});
        resp_q.push_back({4{32'h0000_00D2}});
        resp_q.push_back({4{32'h0000_00E1}});
        resp_q.push_back({4{32'h0000_00D3}});
        dc_miss = 1; dc_miss_addr = 32'h0000_5000;
        ic_miss = 1; ic_miss_addr = 32'h0000_6000;
        collect(4, 1, 120);
        if (got_q.size() == 4) begin
            check("starve_0_dc", 512'(got_q[0]), 512'({4'd0, {4{32'h0000_00D1}}}));
            check("starve_1_dc", 512'(got_q[1]), 512'({4'd0, {4{32'h0000_00D2}}}));
            check("starve_2_ic", 512'(got_q[2]), 512'({4'd2, {4{32'h0000_00E1}}}));
            check("starve_3_dc", 512'(got_q[3]), 512'({4'd0, {4{32'h0000_00D3}}}));
        end
        @(negedge clk);

        // requester drops mid-transaction: still completes and acks
        ack_dly = 2;
        resp_q.push_back(128'h0000_0000_0000_0000_0000_0000_0BAD_F00D);
        io_access = 1; io_rw = 0; io_addr = 32'h0000_F010;
        @(negedge clk);
        io_access = 0;
        wait_ack(1, 40, lat, data);
        check("drop_mid_latency", 512'(lat), 512'(3));
        check("drop_mid_data", 512'(data), 512'(32'h0BAD_F00D));

        // request raised in RECOVER and withdrawn before IDLE: never granted
        obs_q.delete();
        ack_dly = 1;
        resp_q.push_back('0);
        io_access = 1; io_rw = 1; io_addr = 32'h0000_F00C; io_wr_data = 32'hA5A5_0001;
        got = 0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (io_ack) got = 1;
        end
        check("rec_io_ack", 512'(got), 512'(1));
        check("rec_io_wr_rdata_zero", 512'(io_rd_data), 512'(0));
        io_access = 0;
        ic_miss = 1; ic_miss_addr = 32'h0000_BEE0;
        @(negedge clk);
        ic_miss = 0;
        quiet(5, acks_n);
        check("rec_no_ack", 512'(acks_n), 512'(0));
        check("rec_no_grant", 512'(obs_q.size()), 512'(1));

        // reset while FILL holds bus_req: outputs clear at once, no ack
        ack_dly = 20;
        dc_miss = 1; dc_miss_addr = 32'h0000_9990; dc_evict = 0;
        repeat (2) @(negedge clk);
        check("rst_mid_bus_req", 512'(bus_req), 512'(1));
        rst_n = 0;
        #1;
        check("rst_mid_outputs_async", all_outs(), '0);
        dc_miss = 0;
        repeat (2) @(negedge clk);
        check("rst_mid_outputs_held", all_outs(), '0);
        rst_n = 1;
        quiet(5, acks_n);
        check("rst_mid_no_ack", 512'(acks_n), 512'(0));
        check("rst_mid_no_new_req", 512'(bus_req), 512'(0));

        obs_q.delete(); start_q.delete(); ack_cyc_q.delete(); resp_q.delete();
        ack_dly = 1;
        resp_q.push_back({4{32'h600D_CAFE}});
        dc_miss = 1; dc_miss_addr = 32'h0000_AAA0;
        wait_ack(0, 40, lat, data);
        check("post_rst_latency", 512'(lat), 512'(3));
        check("post_rst_data", 512'(data), 512'({4{32'h600D_CAFE}}));
        if (obs_q.size() >= 1)
            check("post_rst_bus", 512'(mask_rd(obs_q[0])), 512'({2'b00, 32'h0000_AAA0, 128'd0}));
        check("bus_err_low", 512'(bus_err), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
